// File: rtl/sram_controller.sv
// Wait-stated controller for an external asynchronous 32-bit SRAM, serving single-outstanding CPU reads/writes.
// Optional `define MEMCTL_STATS_EN adds saturating rd_count/wr_count completion counters.
module sram_controller #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 2   // legal 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_read_req,
  input  logic              memory_write_req,
  input  logic [ADDR_W-1:0] memory_addr,
  input  logic [DATA_W-1:0] memory_data_o,
  output logic [DATA_W-1:0] memory_data_i,
  output logic              memory_busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
`ifdef MEMCTL_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t              state, state_nx;
  logic [3:0]          wait_cnt, wait_cnt_nx;
  logic                is_write, is_write_nx;
  logic [DATA_W-1:0]   rdata_nx;
  logic                busy_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   dq_nx;
  logic                dq_oe_nx;
  logic                ce_n_nx;
  logic                oe_n_nx;
  logic                we_n_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      is_write      <= 1'b0;
      memory_data_i <= '0;
      memory_busy   <= 1'b0;
      sram_addr     <= '0;
      sram_dq_o     <= '0;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
    end else begin
      state         <= state_nx;
      wait_cnt      <= wait_cnt_nx;
      is_write      <= is_write_nx;
      memory_data_i <= rdata_nx;
      memory_busy   <= busy_nx;
      sram_addr     <= addr_nx;
      sram_dq_o     <= dq_nx;
      sram_dq_oe    <= dq_oe_nx;
      sram_ce_n     <= ce_n_nx;
      sram_oe_n     <= oe_n_nx;
      sram_we_n     <= we_n_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    is_write_nx = is_write;
    rdata_nx    = memory_data_i;
    busy_nx     = memory_busy;
    addr_nx     = sram_addr;
    dq_nx       = sram_dq_o;
    dq_oe_nx    = sram_dq_oe;
    ce_n_nx     = sram_ce_n;
    oe_n_nx     = sram_oe_n;
    we_n_nx     = sram_we_n;

    case (state)
      IDLE: begin
        // Write has priority; a simultaneous read request is dropped.
        if (memory_write_req) begin
          is_write_nx = 1'b1;
          addr_nx     = memory_addr;
          dq_nx       = memory_data_o;
          dq_oe_nx    = 1'b1;
          busy_nx     = 1'b1;
          ce_n_nx     = 1'b0;
          state_nx    = SETUP;
        end else if (memory_read_req) begin
          is_write_nx = 1'b0;
          addr_nx     = memory_addr;
          busy_nx     = 1'b1;
          ce_n_nx     = 1'b0;
          state_nx    = SETUP;
        end
      end
      SETUP: begin
        wait_cnt_nx = 4'(WAIT_STATES - 1);
        if (is_write) we_n_nx = 1'b0;
        else          oe_n_nx = 1'b0;
        state_nx = ACCESS;
      end
      ACCESS: begin
        if (wait_cnt == '0) begin
          oe_n_nx = 1'b1;
          we_n_nx = 1'b1;
          if (!is_write) rdata_nx = sram_dq_i;
          state_nx = HOLD;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      HOLD: begin
        ce_n_nx  = 1'b1;
        dq_oe_nx = 1'b0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MEMCTL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == HOLD) begin
      if (is_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: word-level memory reference model plus a pin-level async SRAM model.
module tb_sram_controller;
  localparam int unsigned WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_read_req, memory_write_req;
  logic [16:0] memory_addr;
  logic [31:0] memory_data_o, memory_data_i;
  logic        memory_busy;
  logic [16:0] sram_addr;
  logic [31:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef MEMCTL_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  sram_controller #(.ADDR_W(17), .DATA_W(32), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .memory_read_req(memory_read_req), .memory_write_req(memory_write_req),
    .memory_addr(memory_addr), .memory_data_o(memory_data_o),
    .memory_data_i(memory_data_i), .memory_busy(memory_busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
`ifdef MEMCTL_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Background contents of the test memory for never-written words.
  function automatic logic [31:0] init_word(input logic [16:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- pin-level SRAM model ----------------
  logic [31:0] sram_mem [logic [16:0]];
  logic [31:0] sram_q;
  assign sram_dq_i = sram_q;

  always @(sram_ce_n, sram_oe_n, sram_addr) begin
    if (sram_ce_n === 1'b0 && sram_oe_n === 1'b0)
      sram_q = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_word(sram_addr);
    else
      sram_q = 32'hBAD0_BAD0;
  end

  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) sram_mem[sram_addr] = sram_dq_o;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          is_write;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] ref_last_rd = '0;
  int          ref_rd_cnt = 0;
  int          ref_wr_cnt = 0;

  function automatic logic [31:0] ref_read(input logic [16:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- monitor ----------------
  bit prev_busy = 1'b0;
  int busy_cycles = 0, oe_cycles = 0, we_cycles = 0, we_outside = 0;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_busy = 1'b0;
      busy_cycles = 0; oe_cycles = 0; we_cycles = 0; we_outside = 0;
    end else begin
      if (memory_busy) begin
        busy_cycles++;
        if (!sram_oe_n) oe_cycles++;
        if (!sram_we_n) begin
          we_cycles++;
          if (sram_ce_n) we_outside++;
        end
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("busy_len", 32'(busy_cycles), 32'(WS + 2));
          check(e.is_write ? "rdata_after_write" : "rdata", memory_data_i, e.data);
          check("oe_low_cycles", 32'(oe_cycles), e.is_write ? 32'd0 : 32'(WS));
          check("we_low_cycles", 32'(we_cycles), e.is_write ? 32'(WS) : 32'd0);
          check("we_outside_ce", 32'(we_outside), 32'd0);
        end
        busy_cycles = 0; oe_cycles = 0; we_cycles = 0; we_outside = 0;
      end
      prev_busy = memory_busy;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int t = 0;
    while (memory_busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("idle_timeout", 32'(t), 32'd0);
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [16:0] a, input logic [31:0] d);
    exp_t e;
    wait_idle();
    memory_read_req  = rd;
    memory_write_req = wr;
    memory_addr      = a;
    memory_data_o    = d;
    e.is_write = wr;
    if (wr) begin
      ref_mem[a] = d;
      e.data = ref_last_rd;
      ref_wr_cnt++;
    end else begin
      ref_last_rd = ref_read(a);
      e.data = ref_last_rd;
      ref_rd_cnt++;
    end
    sb.push_back(e);
    @(negedge clk);
    memory_read_req  = 1'b0;
    memory_write_req = 1'b0;
    memory_addr      = 17'($urandom);   // CPU re-muxes the address bus
    memory_data_o    = $urandom;
  endtask

  task automatic preload(input logic [16:0] a, input logic [31:0] d);
    sram_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  task automatic drain();
    wait_idle();
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [16:0] pool [8] = '{17'h00010, 17'h00020, 17'h1FFFF, 17'h00000,
                            17'h0FFFF, 17'h12345, 17'h00001, 17'h10000};

  initial begin
    reset = 1'b0;
    memory_read_req = 1'b0; memory_write_req = 1'b0;
    memory_addr = '0; memory_data_o = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, memory_busy}, 32'd0);
    check("rst_rdata", memory_data_i, 32'd0);
    check("rst_addr",  {15'd0, sram_addr}, 32'd0);
    check("rst_dq_o",  sram_dq_o, 32'd0);
    check("rst_ctrl",  {28'd0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    reset = 1'b1;
    @(negedge clk);

    // read returning a preloaded word
    preload(17'h00010, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 17'h00010, $urandom);
    // write to top address then read it back
    issue(1'b0, 1'b1, 17'h1FFFF, 32'hA5A5A5A5);
    issue(1'b1, 1'b0, 17'h1FFFF, $urandom);
    // simultaneous read+write: write only
    issue(1'b1, 1'b1, 17'h00020, 32'h0BADCAFE);
    issue(1'b1, 1'b0, 17'h00020, $urandom);
    // request pulsed while busy is ignored
    issue(1'b1, 1'b0, 17'h00001, $urandom);
    memory_read_req = 1'b1;
    memory_addr     = 17'h00010;
    @(negedge clk);
    memory_read_req = 1'b0;
    issue(1'b1, 1'b0, 17'h10000, $urandom);
    drain();

    // asynchronous reset in the middle of a write's ACCESS phase
    memory_write_req = 1'b1;
    memory_addr      = 17'h0ABCD;
    memory_data_o    = 32'h12345678;
    @(negedge clk);
    memory_write_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #5;
    check("mid_access_we", {31'd0, sram_we_n}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_we_n",  {31'd0, sram_we_n}, 32'd1);
    check("rst_mid_ce_n",  {31'd0, sram_ce_n}, 32'd1);
    check("rst_mid_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_mid_busy",  {31'd0, memory_busy}, 32'd0);
    ref_last_rd = '0;
    ref_rd_cnt = 0;
    ref_wr_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 1'b0, 17'h00010, $urandom);

    // randomized traffic, back-to-back
    for (int i = 0; i < 40; i++) begin
      int unsigned op;
      op = $urandom_range(0, 4);
      issue(op inside {0, 1}, op inside {2, 3, 4} ? (op != 4 || 1'b1) : 1'b0,
            pool[$urandom_range(0, 7)], $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    check("sram_top_word", sram_mem.exists(17'h1FFFF) ? sram_mem[17'h1FFFF] : 32'hFFFF_FFFF,
          ref_read(17'h1FFFF));

`ifdef MEMCTL_STATS_EN
    check("rd_count", {16'd0, rd_count}, 32'(ref_rd_cnt));
    check("wr_count", {16'd0, wr_count}, 32'(ref_wr_cnt));
    force dut.rd_count = 16'hFFFF;
    @(negedge clk);
    release dut.rd_count;
    issue(1'b1, 1'b0, 17'h00010, $urandom);
    drain();
    check("rd_count_sat", {16'd0, rd_count}, 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
